t06_apple_eat_detect: RTL and testbench
=======================================

Name: t06_apple_eat_detect

Overview:
Consumer end of the apple-placement interface. Watches the registered apple_location and the snake head, and issues the one-cycle good_collision pulse that drives the apple placer. It also owns the growth bookkeeping (snake length, pending growth, grow strobe), the two-digit BCD score and the win condition. It sits between the movement controller, which supplies move_tick and the head position, and the apple placer / body array.

Parameters:
MAX_LENGTH, 30, body capacity; reaching it raises win
INIT_LENGTH, 2, snake_length after reset or game restart
GROW_PER_APPLE, 1, segments owed per apple eaten (1..3)
LEN_W, 5, width of snake_length; must satisfy 2^LEN_W > MAX_LENGTH
STALE_TICKS, 15, move ticks to wait in EATEN before forcing re-arm

Ports:
system_clk  in  1  system clock, all state on rising edge
nreset  in  1  asynchronous active-low reset
game_active  in  1  high while a game runs; low forces IDLE and re-init
move_tick  in  1  one-cycle strobe; head coordinates are valid this cycle
snake_head_x  in  4  head column
snake_head_y  in  4  head row
apple_location  in  8  {y[7:4], x[3:0]} from the apple placer
good_collision  out  1  one-cycle pulse: apple eaten
grow  out  1  one-cycle pulse: body appends one segment this tick
snake_length  out  LEN_W  current length
score_bcd  out  8  {tens, ones} BCD apples eaten, saturates at 8'h99
win  out  1  sticky: length reached MAX_LENGTH

Behaviour:
- Reset (async, nreset=0): state=IDLE, good_collision=0, grow=0, snake_length=INIT_LENGTH, score_bcd=8'h00, win=0, grow_owed=0, stale_cnt=0, eaten_loc=8'h00.
- FSM states: IDLE, ARMED, EATEN, WIN.
- IDLE: when game_active=1, go to ARMED next cycle. Outputs hold their init values.
- ARMED: on a cycle with move_tick=1 and {snake_head_y, snake_head_x}==apple_location:
  - next cycle good_collision=1 (latency 1 cycle, exactly 1 cycle wide);
  - eaten_loc<=apple_location, stale_cnt<=0, state->EATEN;
  - score_bcd increments in BCD: ones 9 wraps to 0 with tens carry; at 99 it holds.
  - grow_owed += GROW_PER_APPLE.
- EATEN: no new eat detection, even if the head sits on the stale apple.
  - Leave to ARMED on the first cycle where apple_location != eaten_loc.
  - Otherwise count move ticks in stale_cnt; when stale_cnt reaches STALE_TICKS, go to ARMED anyway.
- Growth: independent of FSM state (except IDLE).
  - On move_tick with grow_owed>0 and snake_length<MAX_LENGTH: grow=1 next cycle, snake_length+1, grow_owed-1.
  - Same-tick eat and consume: grow_owed = grow_owed + GROW_PER_APPLE - 1. The grow for that tick uses the pre-eat grow_owed, so an apple eaten with owed=0 produces its grow on the following tick.
  - grow_owed is 3 bits and saturates at 7.
- Win: when snake_length becomes MAX_LENGTH, set win=1 in the same cycle the length updates.
  - State->WIN. In WIN, no good_collision, no grow, and counters freeze.
- game_active=0 in any non-IDLE state: next cycle return to IDLE, restore all reset values except the async path. Any pending good_collision/grow pulse that cycle is suppressed.
- move_tick with game_active=0 is ignored.
- Apple coordinates are compared as raw 8 bits; there is no bounds checking (the placer guarantees in-bounds values).

Test Plan:
- Reset, game_active=1, apple_location=8'h68, head (x=8, y=6) with move_tick -> good_collision=1 exactly 1 cycle later, score_bcd=8'h01; grow=1 on the next move_tick, snake_length 2->3.
- After an eat with apple_location held at 8'h68 and head still at (8,6) over 3 move ticks -> no further good_collision. apple_location changes to 8'h33 -> ARMED next cycle; head (3,3) with move_tick -> good_collision.
- Apple never relocates: 15 move ticks after an eat -> state re-arms. Head on 8'h68 on the 16th tick -> good_collision fires.
- 99 apples eaten, then a 100th -> score_bcd holds 8'h99; carry check: 8'h09 -> 8'h10 on the 10th eat.
- GROW_PER_APPLE=1, MAX_LENGTH=30: 28 eats with move ticks -> snake_length=30, win=1; a subsequent matching tick -> no good_collision, no grow.
- game_active deasserted mid-EATEN with grow_owed=1 -> next cycle snake_length=2, score=8'h00, grow never pulses. Async nreset pulse mid-grow -> outputs at reset values immediately.

Source files
------------

// File: rtl/t06_apple_eat_detect.sv
// rtl/t06_apple_eat_detect.sv - apple eat detection, growth bookkeeping, BCD score and win flag
module t06_apple_eat_detect #(
  parameter int MAX_LENGTH     = 30,
  parameter int INIT_LENGTH    = 2,
  parameter int GROW_PER_APPLE = 1,
  parameter int LEN_W          = 5,
  parameter int STALE_TICKS    = 15
) (
  input  logic             system_clk,
  input  logic             nreset,
  input  logic             game_active,
  input  logic             move_tick,
  input  logic [3:0]       snake_head_x,
  input  logic [3:0]       snake_head_y,
  input  logic [7:0]       apple_location,
  output logic             good_collision,
  output logic             grow,
  output logic [LEN_W-1:0] snake_length,
  output logic [7:0]       score_bcd,
  output logic             win
);

  localparam int STALE_W = $clog2(STALE_TICKS + 1);
  localparam logic [LEN_W-1:0]   MAX_LEN_L  = LEN_W'(MAX_LENGTH);
  localparam logic [LEN_W-1:0]   INIT_LEN_L = LEN_W'(INIT_LENGTH);
  localparam logic [STALE_W-1:0] STALE_L    = STALE_W'(STALE_TICKS);
  localparam logic [3:0]         GROW_L     = 4'(GROW_PER_APPLE);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_EATEN, S_WIN} state_t;

  state_t             r_state;
  logic               r_gc;
  logic               r_grow;
  logic [LEN_W-1:0]   r_len;
  logic [7:0]         r_score;
  logic               r_win;
  logic [2:0]         r_grow_owed;
  logic [STALE_W-1:0] r_stale_cnt;
  logic [7:0]         r_eaten_loc;

  logic               w_hit;
  logic               w_eat;
  logic               w_consume;
  logic [3:0]         w_owed_sum;
  logic [2:0]         w_owed_next;
  logic [LEN_W-1:0]   w_len_inc;
  logic [STALE_W-1:0] w_stale_inc;
  logic [7:0]         w_score_next;
  logic               w_reach_max;

  assign good_collision = r_gc;
  assign grow           = r_grow;
  assign snake_length   = r_len;
  assign score_bcd      = r_score;
  assign win            = r_win;

  assign w_hit       = move_tick && ({snake_head_y, snake_head_x} == apple_location);
  assign w_eat       = (r_state == S_ARMED) && w_hit;
  // The grow decision looks at the pre-eat owed count, so a fresh apple grows on a later tick.
  assign w_consume   = move_tick && (r_grow_owed != 3'd0) && (r_len < MAX_LEN_L);
  assign w_owed_sum  = {1'b0, r_grow_owed} + (w_eat ? GROW_L : 4'd0) - (w_consume ? 4'd1 : 4'd0);
  assign w_owed_next = (w_owed_sum > 4'd7) ? 3'd7 : w_owed_sum[2:0];
  assign w_len_inc   = r_len + 1'b1;
  assign w_stale_inc = r_stale_cnt + 1'b1;
  assign w_reach_max = w_consume && (w_len_inc == MAX_LEN_L);

  // BCD increment of the score, holding at 99
  always_comb begin
    w_score_next = r_score;
    if (r_score != 8'h99) begin
      if (r_score[3:0] == 4'd9) begin
        w_score_next = {r_score[7:4] + 4'd1, 4'd0};
      end else begin
        w_score_next = {r_score[7:4], r_score[3:0] + 4'd1};
      end
    end
  end

  // Game FSM with registered pulses, growth counters, score and win
  always_ff @(posedge system_clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_gc        <= 1'b0;
      r_grow      <= 1'b0;
      r_len       <= INIT_LEN_L;
      r_score     <= 8'h00;
      r_win       <= 1'b0;
      r_grow_owed <= 3'd0;
      r_stale_cnt <= '0;
      r_eaten_loc <= 8'h00;
    end else begin
      r_gc   <= 1'b0;
      r_grow <= 1'b0;
      if ((r_state != S_IDLE) && !game_active) begin
        r_state     <= S_IDLE;
        r_len       <= INIT_LEN_L;
        r_score     <= 8'h00;
        r_win       <= 1'b0;
        r_grow_owed <= 3'd0;
        r_stale_cnt <= '0;
        r_eaten_loc <= 8'h00;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (game_active) r_state <= S_ARMED;
          end
          S_ARMED, S_EATEN: begin
            r_grow_owed <= w_owed_next;
            if (w_consume) begin
              r_grow <= 1'b1;
              r_len  <= w_len_inc;
            end
            if (w_eat) begin
              r_gc        <= 1'b1;
              r_eaten_loc <= apple_location;
              r_stale_cnt <= '0;
              r_score     <= w_score_next;
              r_state     <= S_EATEN;
            end else if (r_state == S_EATEN) begin
              if (apple_location != r_eaten_loc) begin
                r_state     <= S_ARMED;
                r_stale_cnt <= '0;
              end else if (move_tick) begin
                if (w_stale_inc == STALE_L) begin
                  r_state     <= S_ARMED;
                  r_stale_cnt <= '0;
                end else begin
                  r_stale_cnt <= w_stale_inc;
                end
              end
            end
            if (w_reach_max) begin
              r_win   <= 1'b1;
              r_state <= S_WIN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t06_apple_eat_detect.sv
// tb/tb_t06_apple_eat_detect.sv - self-checking bench for t06_apple_eat_detect
module tb_t06_apple_eat_detect;

  logic       system_clk = 1'b0;
  logic       nreset = 1'b0;
  logic       game_active = 1'b0;
  logic       move_tick = 1'b0;
  logic [3:0] snake_head_x = 4'd0;
  logic [3:0] snake_head_y = 4'd0;
  logic [7:0] apple_location = 8'h00;

  logic       gc_d, grow_d, win_d;
  logic [4:0] len_d;
  logic [7:0] score_d;
  logic       gc_b, grow_b, win_b;
  logic [6:0] len_b;
  logic [7:0] score_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic sel_big = 1'b0;

  always #5 system_clk = ~system_clk;

  t06_apple_eat_detect dut (
    .system_clk(system_clk), .nreset(nreset), .game_active(game_active),
    .move_tick(move_tick), .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
    .apple_location(apple_location), .good_collision(gc_d), .grow(grow_d),
    .snake_length(len_d), .score_bcd(score_d), .win(win_d)
  );

  t06_apple_eat_detect #(.MAX_LENGTH(127), .LEN_W(7)) dut_big (
    .system_clk(system_clk), .nreset(nreset), .game_active(game_active),
    .move_tick(move_tick), .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
    .apple_location(apple_location), .good_collision(gc_b), .grow(grow_b),
    .snake_length(len_b), .score_bcd(score_b), .win(win_b)
  );

  typedef struct {
    string      name;
    logic       ga;
    logic       mt;
    logic [3:0] hx;
    logic [3:0] hy;
    logic [7:0] apple;
    logic       e_gc;
    logic       e_grow;
    int         e_len;
    logic [7:0] e_score;
    logic       e_win;
  } vec_t;

  vec_t exp_q[$];

  function automatic vec_t mk(input string nm, input logic ga, input logic mt,
                              input logic [3:0] hx, input logic [3:0] hy, input logic [7:0] ap,
                              input logic gc, input logic gr, input int len,
                              input logic [7:0] sc, input logic w);
    vec_t v;
    v.name = nm; v.ga = ga; v.mt = mt; v.hx = hx; v.hy = hy; v.apple = ap;
    v.e_gc = gc; v.e_grow = gr; v.e_len = len; v.e_score = sc; v.e_win = w;
    return v;
  endfunction

  function automatic logic [7:0] bcd(input int n);
    int m;
    m = (n > 99) ? 99 : n;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic compare_now(input string nm, input logic e_gc, input logic e_grow,
                             input int e_len, input logic [7:0] e_score, input logic e_win);
    logic o_gc, o_grow, o_win;
    int o_len;
    logic [7:0] o_score;
    o_gc    = sel_big ? gc_b : gc_d;
    o_grow  = sel_big ? grow_b : grow_d;
    o_len   = sel_big ? int'(len_b) : int'(len_d);
    o_score = sel_big ? score_b : score_d;
    o_win   = sel_big ? win_b : win_d;
    n_tests++;
    if (o_gc !== e_gc || o_grow !== e_grow || o_len != e_len || o_score !== e_score || o_win !== e_win) begin
      n_fail++;
      $display("FAIL %s: got gc=%0b grow=%0b len=%0d score=%h win=%0b, expected gc=%0b grow=%0b len=%0d score=%h win=%0b",
               nm, o_gc, o_grow, o_len, o_score, o_win, e_gc, e_grow, e_len, e_score, e_win);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    game_active = v.ga; move_tick = v.mt;
    snake_head_x = v.hx; snake_head_y = v.hy; apple_location = v.apple;
    exp_q.push_back(v);
    @(posedge system_clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = exp_q.pop_front();
      compare_now(e.name, e.e_gc, e.e_grow, e.e_len, e.e_score, e.e_win);
    end
  endtask

  vec_t tbl[10];

  initial begin
    logic [7:0] loc;
    tbl[0] = mk("arm",        1, 0, 4'd0, 4'd0, 8'h68, 0, 0, 2, 8'h00, 0);
    tbl[1] = mk("eat68",      1, 1, 4'd8, 4'd6, 8'h68, 1, 0, 2, 8'h01, 0);
    tbl[2] = mk("gc_width",   1, 0, 4'd8, 4'd6, 8'h68, 0, 0, 2, 8'h01, 0);
    tbl[3] = mk("stale1_grow",1, 1, 4'd8, 4'd6, 8'h68, 0, 1, 3, 8'h01, 0);
    tbl[4] = mk("stale2",     1, 1, 4'd8, 4'd6, 8'h68, 0, 0, 3, 8'h01, 0);
    tbl[5] = mk("stale3",     1, 1, 4'd8, 4'd6, 8'h68, 0, 0, 3, 8'h01, 0);
    tbl[6] = mk("relocate33", 1, 0, 4'd0, 4'd0, 8'h33, 0, 0, 3, 8'h01, 0);
    tbl[7] = mk("eat33",      1, 1, 4'd3, 4'd3, 8'h33, 1, 0, 3, 8'h02, 0);
    tbl[8] = mk("idle33",     1, 0, 4'd0, 4'd0, 8'h33, 0, 0, 3, 8'h02, 0);
    tbl[9] = mk("grow33",     1, 1, 4'd0, 4'd0, 8'h33, 0, 1, 4, 8'h02, 0);

    repeat (2) @(posedge system_clk);
    #1;
    compare_now("reset_def", 0, 0, 2, 8'h00, 0);
    sel_big = 1'b1;
    compare_now("reset_big", 0, 0, 2, 8'h00, 0);
    sel_big = 1'b0;
    nreset = 1'b1;

    for (int i = 0; i < 10; i++) step(tbl[i]);

    // Apple never relocates: ticks 2..15 are blind, the 16th re-eats.
    for (int i = 2; i <= 15; i++) step(mk($sformatf("stale_tick%0d", i), 1, 1, 4'd3, 4'd3, 8'h33, 0, 0, 4, 8'h02, 0));
    step(mk("stale_rearm_eat", 1, 1, 4'd3, 4'd3, 8'h33, 1, 0, 4, 8'h03, 0));

    // Relocate-and-grow then eat, until length reaches 30.
    for (int k = 1; k <= 26; k++) begin
      loc = 8'(k + 16);
      step(mk($sformatf("win_grow%0d", k), 1, 1, 4'd0, 4'd0, loc, 0, 1, 4 + k, bcd(2 + k), (k == 26)));
      if (k < 26) step(mk($sformatf("win_eat%0d", k), 1, 1, loc[3:0], loc[7:4], loc, 1, 0, 4 + k, bcd(3 + k), 0));
      else        step(mk("win_frozen", 1, 1, loc[3:0], loc[7:4], loc, 0, 0, 30, bcd(28), 1));
    end

    // Game restart from WIN, then abort mid-EATEN with a pending grow.
    step(mk("restart_reinit", 0, 0, 4'd0, 4'd0, 8'h68, 0, 0, 2, 8'h00, 0));
    step(mk("restart_idle",   0, 0, 4'd0, 4'd0, 8'h68, 0, 0, 2, 8'h00, 0));
    step(mk("restart_arm",    1, 0, 4'd0, 4'd0, 8'h68, 0, 0, 2, 8'h00, 0));
    step(mk("restart_eat",    1, 1, 4'd8, 4'd6, 8'h68, 1, 0, 2, 8'h01, 0));
    step(mk("abort_eaten",    0, 1, 4'd8, 4'd6, 8'h68, 0, 0, 2, 8'h00, 0));
    step(mk("abort_no_grow",  0, 1, 4'd8, 4'd6, 8'h68, 0, 0, 2, 8'h00, 0));

    // Score carry and saturation on the long-body instance.
    sel_big = 1'b1;
    step(mk("sat_arm", 1, 0, 4'd0, 4'd0, 8'h68, 0, 0, 2, 8'h00, 0));
    for (int k = 1; k <= 100; k++) begin
      loc = 8'(k + 16);
      step(mk($sformatf("sat_move%0d", k), 1, 1, 4'd0, 4'd0, loc, 0, (k > 1), k + 1, bcd(k - 1), 0));
      step(mk($sformatf("sat_eat%0d", k), 1, 1, loc[3:0], loc[7:4], loc, 1, 0, k + 1, bcd(k), 0));
    end

    // Async reset while a grow pulse is on the outputs.
    step(mk("pre_reset_grow", 1, 1, 4'd0, 4'd0, loc, 0, 1, 102, 8'h99, 0));
    #2;
    nreset = 1'b0;
    #1;
    compare_now("async_reset_big", 0, 0, 2, 8'h00, 0);
    sel_big = 1'b0;
    compare_now("async_reset_def", 0, 0, 2, 8'h00, 0);
    #3;
    nreset = 1'b1;
    @(posedge system_clk);
    #1;
    sel_big = 1'b1;
    step(mk("post_reset_arm", 1, 0, 4'd0, 4'd0, 8'h68, 0, 0, 2, 8'h00, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
